rst_seq: RTL and testbench
==========================

RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter N_DOM, default 4: number of sequenced reset domains.
REQ-002 SHALL have parameter LOCK_CYC, default 8: consecutive locked_i=1 cycles required before release starts.
REQ-003 SHALL have parameter STAGE_DLY, default 16: cycles between successive domain release/assert steps (>=1).
REQ-004 clk_i  input  1  single clock; all logic on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 locked_i  input  1  clock-source lock status, already synchronous to clk_i.
REQ-007 en_i  input  1  1 = bring domains up, 0 = take domains down.
REQ-008 clr_fault_i  input  1  single-cycle pulse clearing fault_o.
REQ-009 dom_rst_n_o  output  N_DOM  per-domain active-low reset, registered.
REQ-010 ready_o  output  1  all domains released, sequence in RUN.
REQ-011 busy_o  output  1  sequencing in progress.
REQ-012 fault_o  output  1  sticky: lock lost while any domain released or releasing.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT_LOCK, RELEASE, RUN, ASSERT; all outputs registered.
REQ-014 Priority per cycle SHALL be: rst_i > lock loss > en_i > counters.
REQ-015 IDLE: all dom_rst_n_o=0; en_i=1 -> WAIT_LOCK next edge.
REQ-016 WAIT_LOCK: lock counter increments while locked_i=1, clears to 0 on locked_i=0; on LOCK_CYC-th consecutive 1 -> RELEASE with idx=0, stage counter=0; en_i=0 -> IDLE.
REQ-017 RELEASE: stage counter increments per cycle; at count STAGE_DLY-1 set dom_rst_n_o[idx]=1, counter=0, idx+1; domain k SHALL release exactly (k+1)*STAGE_DLY cycles after RELEASE entry.
REQ-018 After release of domain N_DOM-1 the FSM SHALL enter RUN on the same edge; ready_o=1 on that edge.
REQ-019 RUN: ready_o=1, busy_o=0; en_i=0 -> ASSERT with idx=N_DOM-1, counter=0, ready_o=0 on same edge.
REQ-020 ASSERT: at count STAGE_DLY-1 clear dom_rst_n_o[idx], idx-1; after domain 0 cleared -> IDLE; order strictly reverse of release.
REQ-021 en_i=0 in RELEASE: -> ASSERT starting at highest released index; if none released -> IDLE directly.
REQ-022 en_i=1 during ASSERT SHALL be ignored until IDLE reached; then normal IDLE rule applies.
REQ-023 locked_i=0 in RELEASE, RUN or ASSERT: next edge all dom_rst_n_o=0, ready_o=0, fault_o=1, lock/stage counters=0; state -> WAIT_LOCK if en_i=1, else IDLE.
REQ-024 locked_i=0 in IDLE or WAIT_LOCK SHALL NOT set fault_o.
REQ-025 clr_fault_i=1 clears fault_o next edge, unless a new fault occurs same cycle (fault_o stays 1).
REQ-026 busy_o=1 exactly in WAIT_LOCK, RELEASE, ASSERT.
REQ-027 Counters SHALL be sized clog2 of their limits; no wrap possible since counters clear on terminal count.
REQ-028 dom_rst_n_o SHALL only change one bit per edge except on lock loss or rst_i (all clear).

Reset
REQ-029 rst_i=1 on an edge: state IDLE, dom_rst_n_o=0, ready_o=0, busy_o=0, fault_o=0, all counters 0, regardless of state (including mid-RELEASE/ASSERT).
REQ-030 Release of rst_i SHALL NOT itself start sequencing; en_i and locked_i required.

Verification
REQ-031 Defaults, locked_i=1, en_i 0->1 at cycle 0: WAIT_LOCK cycle 1, RELEASE after 8 locks, dom_rst_n_o 0001/0011/0111/1111 at +16/+32/+48/+64, ready_o=1 with 1111.
REQ-032 From RUN, en_i=0: ready_o=0 next edge, dom_rst_n_o 0111/0011/0001/0000 at +16 steps, then IDLE, busy_o=0.
REQ-033 WAIT_LOCK with locked_i glitch low at 5th cycle: lock counter restarts; release begins only after 8 fresh consecutive 1s; fault_o stays 0.
REQ-034 RUN, locked_i=0 one cycle: dom_rst_n_o=0000, fault_o=1, WAIT_LOCK; relock re-sequences; clr_fault_i pulse -> fault_o=0; clr_fault_i coincident with lock loss -> fault_o=1.
REQ-035 en_i=0 after domains 0,1 released: ASSERT clears bit 1 at +16 then bit 0 at +32, IDLE; en_i=1 pulse mid-ASSERT ignored.
REQ-036 rst_i=1 mid-RELEASE with dom_rst_n_o=0011: next edge all outputs 0, state IDLE.

Source files
------------

// File: rtl/rst_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rst_seq
//  Description : Sequenced multi-domain reset controller. Waits for a stable
//                clock lock, releases domain resets one at a time in
//                ascending order, and asserts them again in reverse order.
//                A lock loss while any domain is live drops every reset at
//                once and raises a sticky fault flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module rst_seq #(
    parameter int N_DOM     = 4,
    parameter int LOCK_CYC  = 8,
    parameter int STAGE_DLY = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             locked_i,
    input  logic             en_i,
    input  logic             clr_fault_i,
    output logic [N_DOM-1:0] dom_rst_n_o,
    output logic             ready_o,
    output logic             busy_o,
    output logic             fault_o
);

    // Counter widths; a limit of 1 still needs a 1-bit register.
    localparam int c_LCW = (LOCK_CYC  > 1) ? $clog2(LOCK_CYC)  : 1;
    localparam int c_SCW = (STAGE_DLY > 1) ? $clog2(STAGE_DLY) : 1;
    localparam int c_IW  = (N_DOM     > 1) ? $clog2(N_DOM)     : 1;

    localparam logic [c_LCW-1:0] c_LOCK_LAST  = c_LCW'(LOCK_CYC - 1);
    localparam logic [c_SCW-1:0] c_STAGE_LAST = c_SCW'(STAGE_DLY - 1);
    localparam logic [c_IW-1:0]  c_IDX_LAST   = c_IW'(N_DOM - 1);
    localparam logic [c_LCW-1:0] c_LCNT_ONE   = c_LCW'(1);
    localparam logic [c_SCW-1:0] c_SCNT_ONE   = c_SCW'(1);
    localparam logic [c_IW-1:0]  c_IDX_ONE    = c_IW'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_RELEASE   = 3'd2,
        S_RUN       = 3'd3,
        S_ASSERT    = 3'd4
    } state_t;

    state_t             r_state;
    logic [c_LCW-1:0]   r_lock_cnt;
    logic [c_SCW-1:0]   r_stage_cnt;
    logic [c_IW-1:0]    r_idx;
    logic [N_DOM-1:0]   r_dom_rst_n;
    logic               r_ready;
    logic               r_busy;
    logic               r_fault;
    logic               w_lock_lost;

    // Losing lock only matters once a domain is released or about to be.
    assign w_lock_lost = !locked_i &&
                         ((r_state == S_RELEASE) || (r_state == S_RUN) ||
                          (r_state == S_ASSERT));

    // Sequencer FSM; every output is set on the transition that implies it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_lock_cnt  <= '0;
            r_stage_cnt <= '0;
            r_idx       <= '0;
            r_dom_rst_n <= '0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_fault     <= 1'b0;
        end else if (w_lock_lost) begin
            // Fault wins over a same-cycle clear request.
            r_dom_rst_n <= '0;
            r_ready     <= 1'b0;
            r_fault     <= 1'b1;
            r_lock_cnt  <= '0;
            r_stage_cnt <= '0;
            r_idx       <= '0;
            r_state     <= en_i ? S_WAIT_LOCK : S_IDLE;
            r_busy      <= en_i;
        end else begin
            if (clr_fault_i) begin
                r_fault <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (en_i) begin
                        r_state    <= S_WAIT_LOCK;
                        r_busy     <= 1'b1;
                        r_lock_cnt <= '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (!en_i) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_lock_cnt <= '0;
                    end else if (!locked_i) begin
                        r_lock_cnt <= '0;
                    end else if (r_lock_cnt == c_LOCK_LAST) begin
                        r_state     <= S_RELEASE;
                        r_lock_cnt  <= '0;
                        r_stage_cnt <= '0;
                        r_idx       <= '0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + c_LCNT_ONE;
                    end
                end
                S_RELEASE: begin
                    if (!en_i) begin
                        // Unwind only what has been released so far.
                        r_stage_cnt <= '0;
                        if (r_idx == '0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_ASSERT;
                            r_idx   <= r_idx - c_IDX_ONE;
                        end
                    end else if (r_stage_cnt == c_STAGE_LAST) begin
                        r_dom_rst_n[r_idx] <= 1'b1;
                        r_stage_cnt        <= '0;
                        if (r_idx == c_IDX_LAST) begin
                            r_state <= S_RUN;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx <= r_idx + c_IDX_ONE;
                        end
                    end else begin
                        r_stage_cnt <= r_stage_cnt + c_SCNT_ONE;
                    end
                end
                S_RUN: begin
                    if (!en_i) begin
                        r_state     <= S_ASSERT;
                        r_idx       <= c_IDX_LAST;
                        r_stage_cnt <= '0;
                        r_ready     <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                S_ASSERT: begin
                    // en_i is deliberately not looked at until IDLE.
                    if (r_stage_cnt == c_STAGE_LAST) begin
                        r_dom_rst_n[r_idx] <= 1'b0;
                        r_stage_cnt        <= '0;
                        if (r_idx == '0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx <= r_idx - c_IDX_ONE;
                        end
                    end else begin
                        r_stage_cnt <= r_stage_cnt + c_SCNT_ONE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_dom_rst_n <= '0;
                    r_ready     <= 1'b0;
                    r_busy      <= 1'b0;
                    r_lock_cnt  <= '0;
                    r_stage_cnt <= '0;
                    r_idx       <= '0;
                end
            endcase
        end
    end

    assign dom_rst_n_o = r_dom_rst_n;
    assign ready_o     = r_ready;
    assign busy_o      = r_busy;
    assign fault_o     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rst_seq
//  Description : Directed testbench for rst_seq. Stimulus pushes expected
//                outputs, stamped with the cycle they apply to, into a
//                scoreboard queue; a monitor compares them on falling edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rst_seq;

    logic       clk_i;
    logic       rst_i;
    logic       locked_i;
    logic       en_i;
    logic       clr_fault_i;
    logic [3:0] dom_rst_n_o;
    logic       ready_o;
    logic       busy_o;
    logic       fault_o;

    rst_seq #(
        .N_DOM     (4),
        .LOCK_CYC  (8),
        .STAGE_DLY (16)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .locked_i    (locked_i),
        .en_i        (en_i),
        .clr_fault_i (clr_fault_i),
        .dom_rst_n_o (dom_rst_n_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .fault_o     (fault_o)
    );

    typedef struct {
        int         cyc;
        logic [3:0] dom;
        logic       rdy;
        logic       bsy;
        logic       flt;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Count rising edges; falling-edge observers see a stable value.
    always @(posedge clk_i) cyc <= cyc + 1;

    // Expectation for the outputs seen k rising edges from now.
    function automatic void expect_at(input int k, input logic [3:0] dom,
                                      input logic rdy, input logic bsy,
                                      input logic flt, input string name);
        exp_t e;
        e.cyc  = cyc + k;
        e.dom  = dom;
        e.rdy  = rdy;
        e.bsy  = bsy;
        e.flt  = flt;
        e.name = name;
        q.push_back(e);
    endfunction

    // Immediate comparison of the current outputs.
    task automatic check_now(input logic [3:0] dom, input logic rdy,
                             input logic bsy, input logic flt,
                             input string name);
        n_chk++;
        if (dom_rst_n_o !== dom) begin
            n_fail++;
            $display("FAIL %s dom @cyc %0d: got %b, expected %b",
                     name, cyc, dom_rst_n_o, dom);
        end
        if (ready_o !== rdy) begin
            n_fail++;
            $display("FAIL %s rdy @cyc %0d: got %b, expected %b",
                     name, cyc, ready_o, rdy);
        end
        if (busy_o !== bsy) begin
            n_fail++;
            $display("FAIL %s bsy @cyc %0d: got %b, expected %b",
                     name, cyc, busy_o, bsy);
        end
        if (fault_o !== flt) begin
            n_fail++;
            $display("FAIL %s flt @cyc %0d: got %b, expected %b",
                     name, cyc, fault_o, flt);
        end
    endtask

    // Monitor: pop and compare every expectation due this cycle.
    always @(negedge clk_i) begin
        int i;
        i = 0;
        while (i < q.size()) begin
            if (q[i].cyc <= cyc) begin
                n_chk++;
                if (q[i].cyc < cyc || dom_rst_n_o !== q[i].dom ||
                    ready_o !== q[i].rdy || busy_o !== q[i].bsy ||
                    fault_o !== q[i].flt) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got dom=%b rdy=%b bsy=%b flt=%b, expected dom=%b rdy=%b bsy=%b flt=%b",
                             q[i].name, cyc, dom_rst_n_o, ready_o, busy_o, fault_o,
                             q[i].dom, q[i].rdy, q[i].bsy, q[i].flt);
                end
                q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i       = 1'b1;
        locked_i    = 1'b1;
        en_i        = 1'b0;
        clr_fault_i = 1'b0;

        // Reset state, and reset release alone does not start sequencing.
        tick(2);
        check_now(4'b0000, 1'b0, 1'b0, 1'b0, "reset_now");
        expect_at(1, 4'b0000, 1'b0, 1'b0, 1'b0, "reset_state");
        tick(1);
        rst_i = 1'b0;
        expect_at(5, 4'b0000, 1'b0, 1'b0, 1'b0, "no_start_after_rst");
        tick(6);
        check_now(4'b0000, 1'b0, 1'b0, 1'b0, "idle_now");

        // Full bring-up.
        en_i = 1'b1;
        expect_at(1,  4'b0000, 1'b0, 1'b1, 1'b0, "wait_lock");
        expect_at(8,  4'b0000, 1'b0, 1'b1, 1'b0, "still_locking");
        expect_at(24, 4'b0000, 1'b0, 1'b1, 1'b0, "rel_d0_hold");
        expect_at(25, 4'b0001, 1'b0, 1'b1, 1'b0, "rel_d0");
        expect_at(41, 4'b0011, 1'b0, 1'b1, 1'b0, "rel_d1");
        expect_at(57, 4'b0111, 1'b0, 1'b1, 1'b0, "rel_d2");
        expect_at(72, 4'b0111, 1'b0, 1'b1, 1'b0, "rel_d3_hold");
        expect_at(73, 4'b1111, 1'b1, 1'b0, 1'b0, "run");
        tick(75);
        check_now(4'b1111, 1'b1, 1'b0, 1'b0, "run_now");

        // Orderly take-down from RUN.
        en_i = 1'b0;
        expect_at(1,  4'b1111, 1'b0, 1'b1, 1'b0, "assert_entry");
        expect_at(16, 4'b1111, 1'b0, 1'b1, 1'b0, "assert_hold");
        expect_at(17, 4'b0111, 1'b0, 1'b1, 1'b0, "assert_d3");
        expect_at(33, 4'b0011, 1'b0, 1'b1, 1'b0, "assert_d2");
        expect_at(49, 4'b0001, 1'b0, 1'b1, 1'b0, "assert_d1");
        expect_at(65, 4'b0000, 1'b0, 1'b0, 1'b0, "assert_idle");
        tick(66);
        check_now(4'b0000, 1'b0, 1'b0, 1'b0, "down_now");

        // Lock glitch on the 5th WAIT_LOCK cycle restarts the count.
        en_i = 1'b1;
        tick(5);
        locked_i = 1'b0;
        expect_at(1, 4'b0000, 1'b0, 1'b1, 1'b0, "glitch_no_fault");
        tick(1);
        locked_i = 1'b1;
        expect_at(8,  4'b0000, 1'b0, 1'b1, 1'b0, "glitch_relock");
        expect_at(23, 4'b0000, 1'b0, 1'b1, 1'b0, "glitch_no_early");
        expect_at(24, 4'b0001, 1'b0, 1'b1, 1'b0, "glitch_d0");
        expect_at(72, 4'b1111, 1'b1, 1'b0, 1'b0, "glitch_run");
        tick(73);

        // Lock loss in RUN, re-sequence, fault clearing.
        locked_i = 1'b0;
        expect_at(1, 4'b0000, 1'b0, 1'b1, 1'b1, "lock_loss_run");
        tick(1);
        locked_i = 1'b1;
        expect_at(72, 4'b1111, 1'b1, 1'b0, 1'b1, "relock_run");
        tick(73);
        clr_fault_i = 1'b1;
        expect_at(1, 4'b1111, 1'b1, 1'b0, 1'b0, "clr_fault");
        tick(1);
        locked_i = 1'b0;
        expect_at(1, 4'b0000, 1'b0, 1'b1, 1'b1, "clr_vs_loss");
        tick(1);
        locked_i = 1'b1;
        expect_at(1, 4'b0000, 1'b0, 1'b1, 1'b0, "clr_in_wait");
        tick(1);
        clr_fault_i = 1'b0;

        // Abort after domains 0 and 1; en_i pulse mid-ASSERT is ignored.
        tick(40);
        en_i = 1'b0;
        expect_at(1,  4'b0011, 1'b0, 1'b1, 1'b0, "abort_entry");
        expect_at(16, 4'b0011, 1'b0, 1'b1, 1'b0, "abort_hold");
        expect_at(17, 4'b0001, 1'b0, 1'b1, 1'b0, "abort_d1");
        expect_at(33, 4'b0000, 1'b0, 1'b0, 1'b0, "abort_idle");
        expect_at(40, 4'b0000, 1'b0, 1'b0, 1'b0, "en_pulse_ignored");
        tick(5);
        en_i = 1'b1;
        tick(1);
        en_i = 1'b0;
        tick(35);

        // Abort before any domain released goes straight to IDLE.
        en_i = 1'b1;
        expect_at(12, 4'b0000, 1'b0, 1'b1, 1'b0, "release_busy");
        tick(12);
        en_i = 1'b0;
        expect_at(1, 4'b0000, 1'b0, 1'b0, 1'b0, "abort_none");
        tick(3);

        // Lock loss mid-RELEASE, then reset mid-RELEASE with 0011.
        en_i = 1'b1;
        tick(30);
        locked_i = 1'b0;
        expect_at(1, 4'b0000, 1'b0, 1'b1, 1'b1, "lock_loss_rel");
        tick(1);
        locked_i = 1'b1;
        expect_at(44, 4'b0011, 1'b0, 1'b1, 1'b1, "pre_rst");
        tick(44);
        rst_i = 1'b1;
        expect_at(1, 4'b0000, 1'b0, 1'b0, 1'b0, "rst_mid");
        tick(1);
        rst_i = 1'b0;
        en_i  = 1'b0;
        expect_at(3, 4'b0000, 1'b0, 1'b0, 1'b0, "post_rst_idle");
        tick(5);
        check_now(4'b0000, 1'b0, 1'b0, 1'b0, "final_idle_now");

        // Anything left in the scoreboard was never compared.
        while (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: got unchecked entry for cyc %0d, expected check by cyc %0d",
                     q[0].name, q[0].cyc, cyc);
            void'(q.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
